// File: rtl/iir_pkg.sv
// Shared definitions for the biquad cascade: default widths, coefficient
// slot indices and the sequencing FSM state encoding.
package iir_pkg;

    localparam int DW_DEF   = 16;
    localparam int CW_DEF   = 16;
    localparam int FRAC_DEF = 14;
    localparam int NSEC_DEF = 4;

    // Coefficient slots inside one section's bank.
    localparam int NCOEF = 5;
    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } iir_state_e;

endpackage

// File: rtl/iir_biquad_dp.sv
// Combinational Direct Form I multiply-accumulate for one biquad step,
// followed by round-half-up and saturation back to the sample width.
module iir_biquad_dp
    import iir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] x1_i,
    input  logic signed [DW-1:0] x2_i,
    input  logic signed [DW-1:0] y1_i,
    input  logic signed [DW-1:0] y2_i,
    input  logic signed [CW-1:0] b0_i,
    input  logic signed [CW-1:0] b1_i,
    input  logic signed [CW-1:0] b2_i,
    input  logic signed [CW-1:0] a1_i,
    input  logic signed [CW-1:0] a2_i,
    output logic signed [DW-1:0] y_o
);

    // Five DWxCW products need 3 guard bits to sum without overflow; the
    // same headroom also absorbs the rounding constant.
    localparam int AW = DW + CW + 3;
    localparam logic signed [AW-1:0] RND  = AW'(longint'(1) << (FRAC - 1));
    localparam logic signed [AW-1:0] MAXV = AW'((longint'(1) << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic signed [AW-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
    logic signed [AW-1:0] acc, rnd, shf;

    // Exact MAC, round by adding half an LSB, arithmetic shift, then clamp.
    always_comb begin
        p_b0 = AW'(x_i)  * AW'(b0_i);
        p_b1 = AW'(x1_i) * AW'(b1_i);
        p_b2 = AW'(x2_i) * AW'(b2_i);
        p_a1 = AW'(y1_i) * AW'(a1_i);
        p_a2 = AW'(y2_i) * AW'(a2_i);
        acc  = p_b0 + p_b1 + p_b2 - p_a1 - p_a2;
        rnd  = acc + RND;
        shf  = rnd >>> FRAC;
        if (shf > MAXV) begin
            y_o = MAXV[DW-1:0];
        end else if (shf < MINV) begin
            y_o = MINV[DW-1:0];
        end else begin
            y_o = shf[DW-1:0];
        end
    end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC Direct Form I biquads sharing one datapath. A sample is
// walked through the sections one per cycle; per-section delay lines and
// coefficient banks live here and are muxed into the shared datapath.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int NSEC = NSEC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    output logic                 out_valid,
    output logic signed [DW-1:0] y,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_sec,
    input  logic [2:0]           cfg_idx,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 cfg_err,
    input  logic [NSEC-1:0]      sec_bypass,
    input  logic                 clr
);

    localparam logic [2:0]           LAST_SEC = 3'(NSEC - 1);
    localparam logic [3:0]           NSEC_W   = 4'(NSEC);
    localparam logic signed [CW-1:0] UNITY    = CW'(longint'(1) << FRAC);

    iir_state_e           state_q, state_d;
    logic [2:0]           sec_q, sec_d;
    logic signed [DW-1:0] cur_q, cur_d;
    logic signed [DW-1:0] y_q, y_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 step;
    logic                 cfg_ok;

    logic signed [DW-1:0] x1_w [NSEC];
    logic signed [DW-1:0] x2_w [NSEC];
    logic signed [DW-1:0] y1_w [NSEC];
    logic signed [DW-1:0] y2_w [NSEC];
    logic signed [CW-1:0] coef_w [NSEC][NCOEF];

    logic signed [DW-1:0] op_x1, op_x2, op_y1, op_y2;
    logic signed [CW-1:0] op_b0, op_b1, op_b2, op_a1, op_a2;
    logic                 op_byp;
    logic signed [DW-1:0] dp_y;
    logic signed [DW-1:0] sec_out;

    // Select the state and coefficients of the section currently in flight.
    always_comb begin
        op_x1  = '0;
        op_x2  = '0;
        op_y1  = '0;
        op_y2  = '0;
        op_b0  = '0;
        op_b1  = '0;
        op_b2  = '0;
        op_a1  = '0;
        op_a2  = '0;
        op_byp = 1'b0;
        for (int k = 0; k < NSEC; k++) begin
            if (sec_q == 3'(k)) begin
                op_x1  = x1_w[k];
                op_x2  = x2_w[k];
                op_y1  = y1_w[k];
                op_y2  = y2_w[k];
                op_b0  = coef_w[k][B0];
                op_b1  = coef_w[k][B1];
                op_b2  = coef_w[k][B2];
                op_a1  = coef_w[k][A1];
                op_a2  = coef_w[k][A2];
                op_byp = sec_bypass[k];
            end
        end
    end

    iir_biquad_dp #(
        .DW   (DW),
        .CW   (CW),
        .FRAC (FRAC)
    ) u_dp (
        .x_i  (cur_q),
        .x1_i (op_x1),
        .x2_i (op_x2),
        .y1_i (op_y1),
        .y2_i (op_y2),
        .b0_i (op_b0),
        .b1_i (op_b1),
        .b2_i (op_b2),
        .a1_i (op_a1),
        .a2_i (op_a2),
        .y_o  (dp_y)
    );

    // A bypassed section hands its input straight to the next one.
    assign sec_out = op_byp ? cur_q : dp_y;

    // Writes land only while idle so a sample never sees a half-updated bank.
    assign cfg_ok    = cfg_we && (state_q == ST_IDLE) &&
                       ({1'b0, cfg_sec} < NSEC_W) && (cfg_idx <= A2);
    assign cfg_err_d = cfg_we && !cfg_ok;

    // Next-state logic: IDLE accepts, RUN walks sections, DONE presents y.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        cur_d   = cur_q;
        y_d     = y_q;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !clr) begin
                    state_d = ST_RUN;
                    sec_d   = '0;
                    cur_d   = x;
                end
            end
            ST_RUN: begin
                step  = !clr;
                cur_d = sec_out;
                if (sec_q == LAST_SEC) begin
                    state_d = ST_DONE;
                    sec_d   = '0;
                    y_d     = sec_out;
                end else begin
                    sec_d = sec_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Clear aborts whatever is in flight and leaves the last y in place.
        if (clr) begin
            state_d = ST_IDLE;
            sec_d   = '0;
            y_d     = y_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sec_q     <= '0;
            cur_q     <= '0;
            y_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            cur_q     <= cur_d;
            y_q       <= y_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Per-section storage: delay lines and coefficient bank.
    for (genvar gi = 0; gi < NSEC; gi++) begin : g_sec
        logic signed [DW-1:0] x1_q, x2_q, y1_q, y2_q;
        logic signed [CW-1:0] coef_q [NCOEF];
        logic                 upd;

        assign upd = step && (sec_q == 3'(gi)) && !sec_bypass[gi];

        // Shift the delay lines when this section's RUN cycle commits.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                x1_q <= '0;
                x2_q <= '0;
                y1_q <= '0;
                y2_q <= '0;
            end else if (clr) begin
                x1_q <= '0;
                x2_q <= '0;
                y1_q <= '0;
                y2_q <= '0;
            end else if (upd) begin
                x1_q <= cur_q;
                x2_q <= x1_q;
                y1_q <= dp_y;
                y2_q <= y1_q;
            end
        end

        // Coefficients reset to a unity pass-through and survive clr.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int j = 0; j < NCOEF; j++) begin
                    coef_q[j] <= (3'(j) == B0) ? UNITY : '0;
                end
            end else if (cfg_ok && (cfg_sec == 3'(gi))) begin
                for (int j = 0; j < NCOEF; j++) begin
                    if (cfg_idx == 3'(j)) begin
                        coef_q[j] <= cfg_data;
                    end
                end
            end
        end

        assign x1_w[gi]   = x1_q;
        assign x2_w[gi]   = x2_q;
        assign y1_w[gi]   = y1_q;
        assign y2_w[gi]   = y2_q;
        assign coef_w[gi] = coef_q;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE) && !clr;
    assign y         = y_q;
    assign cfg_err   = cfg_err_q;

endmodule
